// File: rtl/display_ctrl.sv
// CPU-facing controller for the 4-digit seven-segment driver: accepts a binary value,
// converts it to BCD by shift-and-add-3, and presents stable digits plus a blink mask.
module display_ctrl #(
  parameter int unsigned VAL_W   = 11,
  parameter int unsigned MAX_VAL = 1999
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic        x1,
  output logic [3:0]  x2,
  output logic [3:0]  x3,
  output logic [3:0]  x4,
  output logic [3:0]  blink
);

  localparam int unsigned SH_W   = 16 + VAL_W;
  localparam int unsigned STEP_W = $clog2(VAL_W);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(VAL_W - 1);

  typedef enum logic [1:0] {IDLE, CONV, LATCH} state_e;

  state_e             state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [SH_W-1:0]    sh_q, sh_d;
  logic [SH_W-1:0]    adj;
  logic [VAL_W-1:0]   value_q, value_d;
  logic [VAL_W-1:0]   sat_val;
  logic               over;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               x1_q, x1_d;
  logic [3:0]         x2_q, x2_d, x3_q, x3_d, x4_q, x4_d;
  logic [3:0]         blink_q, blink_d;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      sh_q    <= '0;
      value_q <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      x1_q    <= 1'b0;
      x2_q    <= '0;
      x3_q    <= '0;
      x4_q    <= '0;
      blink_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sh_q    <= sh_d;
      value_q <= value_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      x3_q    <= x3_d;
      x4_q    <= x4_d;
      blink_q <= blink_d;
    end
  end

  assign over    = (wdata > 32'(MAX_VAL));
  assign sat_val = over ? VAL_W'(MAX_VAL) : wdata[VAL_W-1:0];

  // BCD nibbles sit above the binary field; correct each before the shift.
  always_comb begin
    adj = sh_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (sh_q[VAL_W + 4*i +: 4] >= 4'd5)
        adj[VAL_W + 4*i +: 4] = sh_q[VAL_W + 4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sh_d    = sh_q;
    value_d = value_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    x1_d    = x1_q;
    x2_d    = x2_q;
    x3_d    = x3_q;
    x4_d    = x4_q;
    blink_d = blink_q;

    if (wr_en && addr == 2'd1)
      blink_d = wdata[3:0];

    case (state_q)
      IDLE: begin
        if (wr_en && addr == 2'd0) begin
          value_d = sat_val;
          ovf_d   = over;
          sh_d    = {16'b0, sat_val};
          step_d  = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d   = adj << 1;
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP)
          state_d = LATCH;
      end
      LATCH: begin
        x1_d    = sh_q[VAL_W + 12];
        x2_d    = sh_q[VAL_W + 8 +: 4];
        x3_d    = sh_q[VAL_W + 4 +: 4];
        x4_d    = sh_q[VAL_W +: 4];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (addr)
      2'd0:    rdata = {{(32 - VAL_W){1'b0}}, value_q};
      2'd1:    rdata = {28'b0, blink_q};
      2'd2:    rdata = {30'b0, ovf_q, busy};
      default: rdata = '0;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign ready = !busy;
  assign done  = done_q;
  assign x1    = x1_q;
  assign x2    = x2_q;
  assign x3    = x3_q;
  assign x4    = x4_q;
  assign blink = blink_q;

endmodule
